// File: rtl/vec_stream_drain.sv
// Drains one vector from the tail VecFIFO chunk by chunk and serializes it
// onto an 8-bit valid/ready byte stream with end-of-vector framing.
module vec_stream_drain #(
   parameter int unsigned InVecLength = 4,
   parameter int unsigned WorkingRegs = 1,
   parameter int unsigned ReadLatency = 1,
   parameter int unsigned CountWidth  = 16
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     in_data_ready,
   input  logic [WorkingRegs*8-1:0] in_data,
   output logic                     req_chunk_in,
   output logic [7:0]               out_tdata,
   output logic                     out_tvalid,
   input  logic                     out_tready,
   output logic                     out_tlast,
   output logic                     busy,
   output logic                     vec_done,
   output logic [CountWidth-1:0]    vec_count
);

   localparam int unsigned NumChunks      = (InVecLength + WorkingRegs - 1) / WorkingRegs;
   localparam int unsigned LastChunkBytes = InVecLength - (NumChunks - 1) * WorkingRegs;
   localparam int unsigned ChunkW         = $clog2(NumChunks + 1);
   localparam int unsigned ByteW          = $clog2(WorkingRegs + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, EMIT} state_t;

   state_t                   state, state_next;
   logic                     armed;
   logic [ChunkW-1:0]        chunk_idx;
   logic [ByteW-1:0]         byte_idx;
   logic [1:0]               wait_cnt;
   logic [WorkingRegs*8-1:0] buffer;

   logic                     accept;
   logic                     last_chunk;
   logic                     start;
   logic                     load_chunk;
   logic                     chunk_end;
   int unsigned              chunk_bytes;
   int unsigned              byte_next;

   always_comb begin
      state_next  = state;
      accept      = out_tvalid && out_tready;
      last_chunk  = (32'(chunk_idx) == NumChunks - 1);
      chunk_bytes = last_chunk ? LastChunkBytes : WorkingRegs;
      byte_next   = 32'(byte_idx) + 1;
      start       = 1'b0;
      load_chunk  = 1'b0;
      chunk_end   = 1'b0;
      unique case (state)
         IDLE: begin
            if (in_data_ready && armed) begin
               start      = 1'b1;
               state_next = REQ;
            end
         end
         REQ: state_next = WAIT;
         WAIT: begin
            if (32'(wait_cnt) == ReadLatency - 1) begin
               load_chunk = 1'b1;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (accept && (byte_next == chunk_bytes)) begin
               chunk_end  = 1'b1;
               state_next = last_chunk ? IDLE : REQ;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= state_next;
   end

   // Outputs are registered from state_next so they line up with the state they describe.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         armed        <= 1'b1;
         req_chunk_in <= 1'b0;
         out_tvalid   <= 1'b0;
         out_tlast    <= 1'b0;
         out_tdata    <= '0;
         vec_done     <= 1'b0;
         vec_count    <= '0;
         chunk_idx    <= '0;
         byte_idx     <= '0;
         wait_cnt     <= '0;
         buffer       <= '0;
      end else begin
         req_chunk_in <= (state_next == REQ);
         out_tvalid   <= (state_next == EMIT);
         vec_done     <= chunk_end && last_chunk;
         if (state == IDLE) begin
            if (start)               armed <= 1'b0;
            else if (!in_data_ready) armed <= 1'b1;
         end
         if (start) chunk_idx <= '0;
         if (state == REQ)       wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 2'd1;
         if (load_chunk) begin
            buffer    <= in_data;
            byte_idx  <= '0;
            out_tdata <= in_data[7:0];
            out_tlast <= last_chunk && (LastChunkBytes == 1);
         end else if (chunk_end) begin
            out_tlast <= 1'b0;
            if (last_chunk) vec_count <= vec_count + CountWidth'(1);
            else            chunk_idx <= chunk_idx + ChunkW'(1);
         end else if (state == EMIT && accept) begin
            // Surplus bytes of a partial final chunk are never reached here.
            byte_idx  <= ByteW'(byte_next);
            out_tdata <= buffer[8*byte_next +: 8];
            out_tlast <= last_chunk && (byte_next == LastChunkBytes - 1);
         end
      end
   end

   assign busy = (state != IDLE);

endmodule
